// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush controller for the 5-stage RISC-V pipeline.
// Generates per-register enable and synchronous-clear strobes from the
// instruction in ID, the control bits latched into EX, branch resolution
// and data-memory busy. Tracks load-use stalls and branch flushes, and
// raises a sticky error when the data memory stays busy too long.
module hazard_ctrl #(
    parameter int unsigned INIT_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32,
    parameter logic [1:0]  WBSEL_MEM   = 2'b00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      id_inst,
    input  logic [31:0]      ex_inst,
    input  logic             ex_regWEn,
    input  logic [1:0]       ex_WBSel,
    input  logic             ex_PCSel,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_err
);

    // init counter runs 0..INIT_CYCLES-1; wait counter must be able to hold MEM_TIMEOUT
    localparam int unsigned INIT_W = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES);
    localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [INIT_W-1:0] INIT_LAST  = INIT_W'(INIT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam bit                TIMEOUT_EN = (MEM_TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [INIT_W-1:0] init_q, init_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              mem_err_q, mem_err_d;

    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       load_use;
    logic       unused_inst_bits;

    // Register-field extraction and the conservative load-use compare (both sources always checked)
    always_comb begin
        id_rs1   = id_inst[19:15];
        id_rs2   = id_inst[24:20];
        ex_rd    = ex_inst[11:7];
        load_use = ex_regWEn && (ex_WBSel == WBSEL_MEM) && (ex_rd != 5'd0) &&
                   ((ex_rd == id_rs1) || (ex_rd == id_rs2));
        unused_inst_bits = ^{id_inst[31:25], id_inst[14:0], ex_inst[31:12], ex_inst[6:0]};
    end

    // Next-state, counter updates and zero-latency enable/flush outputs
    always_comb begin
        state_d     = state_q;
        init_d      = init_q;
        wait_d      = wait_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        mem_err_d   = mem_err_q;

        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b0;
        id_ex_flush = 1'b0;
        ex_mem_en   = 1'b0;
        mem_wb_en   = 1'b0;

        case (state_q)
            ST_INIT: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (init_q == INIT_LAST) begin
                    state_d = ST_RUN;
                    init_d  = '0;
                end else begin
                    init_d = init_q + INIT_W'(1);
                end
            end
            // RUN and the release cycle of MEM_WAIT share one priority chain, so a
            // branch or load-use held across a freeze is acted on once, on release.
            ST_RUN, ST_MEM_WAIT: begin
                if (mem_busy) begin
                    state_d = ST_MEM_WAIT;
                    if (state_q == ST_RUN) begin
                        wait_d = WAIT_W'(1);
                    end else if (wait_q != '1) begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                    if (TIMEOUT_EN && (wait_d >= WAIT_LIMIT)) begin
                        mem_err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_RUN;
                    wait_d  = '0;
                    if (ex_PCSel) begin
                        pc_en       = 1'b1;
                        if_id_en    = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_en    = 1'b1;
                        id_ex_flush = 1'b1;
                        ex_mem_en   = 1'b1;
                        mem_wb_en   = 1'b1;
                        if (flush_cnt_q != '1) begin
                            flush_cnt_d = flush_cnt_q + CNT_W'(1);
                        end
                    end else if (load_use) begin
                        id_ex_en    = 1'b1;
                        id_ex_flush = 1'b1;
                        ex_mem_en   = 1'b1;
                        mem_wb_en   = 1'b1;
                        if (stall_cnt_q != '1) begin
                            stall_cnt_d = stall_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        pc_en     = 1'b1;
                        if_id_en  = 1'b1;
                        id_ex_en  = 1'b1;
                        ex_mem_en = 1'b1;
                        mem_wb_en = 1'b1;
                    end
                end
            end
            default: begin
                state_d     = ST_INIT;
                init_d      = '0;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end
        endcase

        // reset forces the hold-and-flush pattern without waiting for an edge
        if (reset) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_en    = 1'b0;
            id_ex_flush = 1'b1;
            ex_mem_en   = 1'b0;
            mem_wb_en   = 1'b0;
        end
    end

    // State and counter registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_INIT;
            init_q      <= '0;
            wait_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_q      <= init_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    // Counter and error outputs straight from their registers
    always_comb begin
        stall_cnt = stall_cnt_q;
        flush_cnt = flush_cnt_q;
        mem_err   = mem_err_q;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed bench for hazard_ctrl. Two instances share stimulus:
// dut uses the default timeout, dut_to uses MEM_TIMEOUT=4.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] id_inst = '0;
    logic [31:0] ex_inst = '0;
    logic        ex_regWEn = 1'b0;
    logic [1:0]  ex_WBSel = 2'b00;
    logic        ex_PCSel = 1'b0;
    logic        mem_busy = 1'b0;

    logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
    logic [31:0] stall_cnt, flush_cnt;
    logic        mem_err;
    logic        pc_en_t, if_id_en_t, if_id_flush_t, id_ex_en_t, id_ex_flush_t, ex_mem_en_t, mem_wb_en_t;
    logic [31:0] stall_cnt_t, flush_cnt_t;
    logic        mem_err_t;

    logic [6:0] outs, outs_t;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned exp_stall = 0;
    int unsigned exp_flush = 0;

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}
    localparam logic [6:0] O_INIT   = 7'b0010100;
    localparam logic [6:0] O_RUN    = 7'b1101011;
    localparam logic [6:0] O_FREEZE = 7'b0000000;
    localparam logic [6:0] O_BRANCH = 7'b1111111;
    localparam logic [6:0] O_LDUSE  = 7'b0001111;

    localparam logic [31:0] LW_X5      = 32'h0000A283; // lw  x5,0(x1)
    localparam logic [31:0] LW_X0      = 32'h0000A003; // lw  x0,0(x1)
    localparam logic [31:0] ADD_6_5_1  = 32'h00128333; // add x6,x5,x1
    localparam logic [31:0] ADD_6_1_5  = 32'h00508333; // add x6,x1,x5
    localparam logic [31:0] ADD_6_0_1  = 32'h00100333; // add x6,x0,x1

    hazard_ctrl #(.INIT_CYCLES(2), .MEM_TIMEOUT(255), .CNT_W(32), .WBSEL_MEM(2'b00)) dut (
        .clk(clk), .reset(reset), .id_inst(id_inst), .ex_inst(ex_inst),
        .ex_regWEn(ex_regWEn), .ex_WBSel(ex_WBSel), .ex_PCSel(ex_PCSel), .mem_busy(mem_busy),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_en(id_ex_en),
        .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_err(mem_err)
    );

    hazard_ctrl #(.INIT_CYCLES(2), .MEM_TIMEOUT(4), .CNT_W(32), .WBSEL_MEM(2'b00)) dut_to (
        .clk(clk), .reset(reset), .id_inst(id_inst), .ex_inst(ex_inst),
        .ex_regWEn(ex_regWEn), .ex_WBSel(ex_WBSel), .ex_PCSel(ex_PCSel), .mem_busy(mem_busy),
        .pc_en(pc_en_t), .if_id_en(if_id_en_t), .if_id_flush(if_id_flush_t), .id_ex_en(id_ex_en_t),
        .id_ex_flush(id_ex_flush_t), .ex_mem_en(ex_mem_en_t), .mem_wb_en(mem_wb_en_t),
        .stall_cnt(stall_cnt_t), .flush_cnt(flush_cnt_t), .mem_err(mem_err_t)
    );

    assign outs   = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en};
    assign outs_t = {pc_en_t, if_id_en_t, if_id_flush_t, id_ex_en_t, id_ex_flush_t, ex_mem_en_t, mem_wb_en_t};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // advance one rising edge, then settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [6:0] exp);
        check({tag, "/outs"}, {25'd0, outs}, {25'd0, exp});
        check({tag, "/outs_to"}, {25'd0, outs_t}, {25'd0, exp});
    endtask

    task automatic check_cnts(input string tag);
        check({tag, "/stall_cnt"}, stall_cnt, exp_stall);
        check({tag, "/flush_cnt"}, flush_cnt, exp_flush);
    endtask

    task automatic idle_inputs();
        id_inst   = '0;
        ex_inst   = '0;
        ex_regWEn = 1'b0;
        ex_WBSel  = 2'b00;
        ex_PCSel  = 1'b0;
        mem_busy  = 1'b0;
    endtask

    task automatic set_load(input logic [31:0] ex_i, input logic [31:0] id_i, input logic [1:0] wbsel);
        ex_inst   = ex_i;
        id_inst   = id_i;
        ex_regWEn = 1'b1;
        ex_WBSel  = wbsel;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // reset state, before any clock edge
        #1;
        check_outs("reset", O_INIT);
        check_cnts("reset");
        check("reset/mem_err", {31'd0, mem_err}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check_outs("init0", O_INIT);
        tick();
        check_outs("init1", O_INIT);
        tick();
        check_outs("run_first", O_RUN);

        // load-use on rs1
        set_load(LW_X5, ADD_6_5_1, 2'b00);
        #1;
        check_outs("lduse_rs1", O_LDUSE);
        tick();
        exp_stall = 1;
        idle_inputs();
        #1;
        check_outs("lduse_bubble", O_RUN);
        check_cnts("lduse_rs1");

        // rd = x0 never stalls
        set_load(LW_X0, ADD_6_0_1, 2'b00);
        #1;
        check_outs("lduse_x0", O_RUN);
        tick();
        check_cnts("lduse_x0");

        // load-use on rs2
        set_load(LW_X5, ADD_6_1_5, 2'b00);
        #1;
        check_outs("lduse_rs2", O_LDUSE);
        tick();
        exp_stall = 2;
        check_cnts("lduse_rs2");

        // matching rd but not a load result
        set_load(LW_X5, ADD_6_5_1, 2'b01);
        #1;
        check_outs("alu_wb", O_RUN);
        tick();
        check_cnts("alu_wb");
        idle_inputs();

        // branch alone
        ex_PCSel = 1'b1;
        #1;
        check_outs("branch", O_BRANCH);
        tick();
        exp_flush = 1;
        ex_PCSel = 1'b0;
        #1;
        check_outs("branch_after", O_RUN);
        check_cnts("branch");

        // branch and load-use together: branch wins
        set_load(LW_X5, ADD_6_5_1, 2'b00);
        ex_PCSel = 1'b1;
        #1;
        check_outs("br_lduse", O_BRANCH);
        tick();
        exp_flush = 2;
        check_cnts("br_lduse");
        idle_inputs();

        // timeout: busy for 10 edges, error rises on the 4th wait edge in dut_to only
        mem_busy = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            #1;
            check_outs($sformatf("to_freeze%0d", k), O_FREEZE);
            tick();
            check($sformatf("to_err%0d", k), {31'd0, mem_err_t}, (k >= 4) ? 32'd1 : 32'd0);
            check($sformatf("to_err_dflt%0d", k), {31'd0, mem_err}, 32'd0);
        end
        mem_busy = 1'b0;
        #1;
        check_outs("to_release", O_RUN);
        tick();
        check("to_sticky", {31'd0, mem_err_t}, 32'd1);
        check_cnts("to_release");

        // memory wait with a branch held across the freeze
        mem_busy = 1'b1;
        ex_PCSel = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            #1;
            check_outs($sformatf("mw_freeze%0d", k), O_FREEZE);
            tick();
            check_cnts($sformatf("mw_freeze%0d", k));
        end
        mem_busy = 1'b0;
        #1;
        check_outs("mw_release", O_BRANCH);
        tick();
        exp_flush = 3;
        ex_PCSel = 1'b0;
        #1;
        check_outs("mw_after", O_RUN);
        check_cnts("mw_release");
        check("mw_err", {31'd0, mem_err}, 32'd0);

        // asynchronous reset in the middle of MEM_WAIT
        mem_busy = 1'b1;
        tick();
        #2;
        reset = 1'b1;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        check_outs("async_rst", O_INIT);
        check_cnts("async_rst");
        check("async_rst/err_to", {31'd0, mem_err_t}, 32'd0);
        check("async_rst/err", {31'd0, mem_err}, 32'd0);
        idle_inputs();
        tick();
        check_outs("rst_hold", O_INIT);
        reset = 1'b0;
        #1;
        check_outs("reinit0", O_INIT);
        tick();
        check_outs("reinit1", O_INIT);
        tick();
        check_outs("rerun", O_RUN);
        check("rerun/err_to", {31'd0, mem_err_t}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage RISC-V pipeline.
- Drives the enable and flush (synchronous-clear) inputs of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers.
- Watches the instruction in ID, the control bits registered into EX, branch resolution and the data-memory busy signal.
- Contains a small FSM (INIT/RUN/MEM_WAIT), a memory-wait timeout counter and stall/flush performance counters.

Parameters:
- INIT_CYCLES, 2: cycles of forced pipeline flush after reset deasserts (>=1).
- MEM_TIMEOUT, 255: consecutive mem_busy cycles before mem_err sets; 0 disables the timeout.
- CNT_W, 32: width of the performance counters.
- WBSEL_MEM, 2'b00: WBSel encoding that selects load data (marks a load in EX).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_inst  in  32  instruction in ID; rs1=[19:15], rs2=[24:20].
- ex_inst  in  32  instruction in EX; rd=[11:7].
- ex_regWEn  in  1  EX instruction writes the register file.
- ex_WBSel  in  2  EX write-back select.
- ex_PCSel  in  1  branch/jump taken, resolved in EX.
- mem_busy  in  1  data memory access in progress; the whole pipeline must hold.
- pc_en  out  1  PC update enable.
- if_id_en  out  1  IF_ID enable.
- if_id_flush  out  1  IF_ID clear.
- id_ex_en  out  1  ID_EX enable.
- id_ex_flush  out  1  ID_EX clear (drives its reset input).
- ex_mem_en  out  1  EX_MEM enable.
- mem_wb_en  out  1  MEM_WB enable.
- stall_cnt  out  CNT_W  count of load-use stall cycles.
- flush_cnt  out  CNT_W  count of branch flush events.
- mem_err  out  1  sticky memory-timeout error flag.

Behaviour:
- Registered state: FSM state, init counter, wait counter, stall_cnt, flush_cnt, mem_err. All are cleared asynchronously by reset: state=INIT, counters=0, mem_err=0.
- Enable/flush outputs are combinational from the current state and inputs (zero latency).
- While reset is high, and in INIT: all *_en=0, if_id_flush=1, id_ex_flush=1.
- INIT lasts exactly INIT_CYCLES rising edges after reset deasserts, then moves to RUN.
- Hazard terms:
  - load_use = ex_regWEn & (ex_WBSel==WBSEL_MEM) & (rd!=0) & (rd==rs1 | rd==rs2). Both sources are compared regardless of instruction format (conservative).
  - Default in RUN: all *_en=1, both flushes=0.
- Priority in RUN, highest first:
  1. mem_busy=1: all *_en=0, flushes=0. Next state MEM_WAIT, wait counter=1.
  2. ex_PCSel=1: all *_en=1, if_id_flush=1, id_ex_flush=1. flush_cnt+1.
  3. load_use=1: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1. stall_cnt+1. Exactly one bubble; the next cycle EX holds the bubble, so load_use clears.
  4. Otherwise: default.
- MEM_WAIT:
  - Outputs are the full freeze (all *_en=0, flushes=0) while mem_busy=1. The wait counter increments, saturating at all-ones.
  - If MEM_TIMEOUT!=0 and the counter reaches MEM_TIMEOUT, mem_err sets on that edge and stays set until reset. The freeze still follows mem_busy.
  - On the first cycle with mem_busy=0: outputs are evaluated with the RUN priority rules (rules 2-4) in that same cycle, and the state returns to RUN. A branch or load-use held during the freeze is therefore applied exactly once, immediately on release.
- Simultaneous events:
  - mem_busy beats ex_PCSel and load_use; neither counter increments during a freeze.
  - ex_PCSel and load_use together: branch wins, and stall_cnt does not increment.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Reset mid-operation (any state) returns to INIT immediately and asynchronously. Outputs switch to the reset values without waiting for a clock edge.

Test Plan:
- Reset, INIT_CYCLES=2: reset high then low → flushes=1 and en=0 for 2 edges after deassert; on the 3rd cycle all en=1, flushes=0.
- Load-use: ex_inst = lw x5 (WBSel=00, regWEn=1), id_inst = add x6,x5,x1 → one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt=1. Same with rd=x0 → no stall.
- Branch: ex_PCSel=1 for 1 cycle → if_id_flush=1, id_ex_flush=1, pc_en=1; flush_cnt=1. ex_PCSel and load_use together → flush only, stall_cnt unchanged.
- Memory wait: mem_busy high 5 cycles with ex_PCSel held → 5 cycles all en=0; on release cycle flushes=1; flush_cnt=1; mem_err=0.
- Timeout: MEM_TIMEOUT=4, mem_busy high 10 cycles → mem_err rises on the 4th wait edge, stays 1 after mem_busy falls, and clears only on reset.
- Async reset: assert reset mid MEM_WAIT between clock edges → outputs go to flush=1/en=0 before the next edge; counters read 0.
